// File: rtl/scc_register_bank_if.sv
// Bus-side port bundle of the SCC register bank: CPU access strobe, address/data
// and the completion/busy indications returned by the bank.
//
// Handshake: the master raises req for exactly one clk with wr/address/wrdata
// stable in that cycle. The slave samples req only while busy=0. Every accepted
// req yields exactly one ready pulse of one clk; rddata is valid only in that
// cycle and reads 0 otherwise. A req presented while busy=1 is dropped, no ready.
interface scc_register_bank_if;
    logic       req;
    logic       wr;
    logic [8:0] address;
    logic [7:0] wrdata;
    logic [7:0] rddata;
    logic       ready;
    logic       busy;

    modport master (
        output req, wr, address, wrdata,
        input  rddata, ready, busy
    );

    modport slave (
        input  req, wr, address, wrdata,
        output rddata, ready, busy
    );
endinterface

// File: rtl/scc_register_bank.sv
// SCC register bank: decodes CPU accesses into per-channel tone registers
// (frequency, volume, enable mask, mode) and an arbitrated wave-RAM port.
// Control accesses complete in one clk; wave-RAM accesses run through a small
// FSM that waits for the clock-enable strobe, fires one SRAM strobe and, for
// reads, waits for sram_q_en with a bounded timeout. The tone generator reads
// the registers of the channel it names on 'active' with one clk of latency.
module scc_register_bank #(
    parameter int NUM_CH  = 5,
    parameter int FREQ_W  = 12,
    parameter int VOL_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                enable,
    scc_register_bank_if.slave  bus,
    output logic [2:0]          sram_id,
    output logic [4:0]          sram_a,
    output logic [7:0]          sram_d,
    output logic                sram_oe,
    output logic                sram_we,
    input  logic [7:0]          sram_q,
    input  logic                sram_q_en,
    input  logic [2:0]          active,
    output logic [FREQ_W-1:0]   freq,
    output logic [VOL_W-1:0]    volume,
    output logic                ch_enable,
    output logic                wave_reset,
    output logic [NUM_CH-1:0]   clear_counter,
    output logic [2:0]          fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_STROBE = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              state;
    logic                wr_q;
    logic [7:0]          tmo_cnt;

    logic [FREQ_W-1:0]   freq_q [NUM_CH];
    logic [VOL_W-1:0]    vol_q  [NUM_CH];
    logic [NUM_CH-1:0]   en_q;
    logic [7:0]          mode_q;

    logic                accept;
    logic                is_ctrl;
    logic [5:0]          offset;
    logic                wave_ch_ok;
    logic                ctrl_wr;
    logic [7:0]          ctrl_rdata;

    // Request qualification: a req counts only while no wave access is in flight.
    always_comb begin
        accept     = bus.req && !bus.busy;
        is_ctrl    = bus.address[8];
        offset     = bus.address[5:0];
        wave_ch_ok = int'(bus.address[7:5]) < NUM_CH;
        ctrl_wr    = accept && is_ctrl && bus.wr;
    end

    // Control readback mux; unmapped offsets read 0xFF, unused bits read 0.
    always_comb begin
        ctrl_rdata = 8'hFF;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(offset) == 2*c)
                ctrl_rdata = freq_q[c][7:0];
            if (int'(offset) == 2*c + 1)
                ctrl_rdata = 8'(freq_q[c][FREQ_W-1:8]);
            if (int'(offset) == 2*NUM_CH + c)
                ctrl_rdata = 8'(vol_q[c]);
        end
        if (int'(offset) == 3*NUM_CH)
            ctrl_rdata = 8'(en_q);
        if (int'(offset) == 3*NUM_CH + 1)
            ctrl_rdata = mode_q;
    end

    // Control register writes, plus a one-clk counter-clear pulse per freq write.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                freq_q[c] <= '0;
                vol_q[c]  <= '0;
            end
            en_q          <= '0;
            mode_q        <= '0;
            clear_counter <= '0;
        end else begin
            clear_counter <= '0;
            if (ctrl_wr) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (int'(offset) == 2*c) begin
                        freq_q[c][7:0]   <= bus.wrdata;
                        clear_counter[c] <= 1'b1;
                    end
                    if (int'(offset) == 2*c + 1) begin
                        freq_q[c][FREQ_W-1:8] <= bus.wrdata[FREQ_W-9:0];
                        clear_counter[c]      <= 1'b1;
                    end
                    if (int'(offset) == 2*NUM_CH + c)
                        vol_q[c] <= bus.wrdata[VOL_W-1:0];
                end
                if (int'(offset) == 3*NUM_CH)
                    en_q <= bus.wrdata[NUM_CH-1:0];
                if (int'(offset) == 3*NUM_CH + 1)
                    mode_q <= bus.wrdata;
            end
        end
    end

    assign wave_reset = mode_q[5];

    // Access FSM: one-clk completion for control and invalid-channel wave
    // accesses; enable-paced single SRAM strobe with bounded read wait otherwise.
    // DONE already shows busy=0, so it accepts a new req exactly like IDLE.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state      <= S_IDLE;
            wr_q       <= 1'b0;
            tmo_cnt    <= '0;
            bus.busy   <= 1'b0;
            bus.ready  <= 1'b0;
            bus.rddata <= '0;
            sram_id    <= '0;
            sram_a     <= '0;
            sram_d     <= '0;
            sram_oe    <= 1'b0;
            sram_we    <= 1'b0;
        end else begin
            bus.ready  <= 1'b0;
            bus.rddata <= '0;
            sram_oe    <= 1'b0;
            sram_we    <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (accept) begin
                        if (is_ctrl) begin
                            bus.ready <= 1'b1;
                            if (!bus.wr)
                                bus.rddata <= ctrl_rdata;
                        end else if (!wave_ch_ok) begin
                            bus.ready <= 1'b1;
                            if (!bus.wr)
                                bus.rddata <= 8'hFF;
                        end else begin
                            state    <= S_ISSUE;
                            bus.busy <= 1'b1;
                            wr_q     <= bus.wr;
                            sram_id  <= bus.address[7:5];
                            sram_a   <= bus.address[4:0];
                            sram_d   <= bus.wrdata;
                        end
                    end
                end
                S_ISSUE: begin
                    if (enable) begin
                        state   <= S_STROBE;
                        sram_oe <= !wr_q;
                        sram_we <= wr_q;
                    end
                end
                S_STROBE: begin
                    if (wr_q) begin
                        state     <= S_DONE;
                        bus.ready <= 1'b1;
                        bus.busy  <= 1'b0;
                    end else begin
                        state   <= S_WAIT;
                        tmo_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (sram_q_en) begin
                        state      <= S_DONE;
                        bus.ready  <= 1'b1;
                        bus.busy   <= 1'b0;
                        bus.rddata <= sram_q;
                    end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
                        state      <= S_DONE;
                        bus.ready  <= 1'b1;
                        bus.busy   <= 1'b0;
                        bus.rddata <= 8'hFF;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign fsm_state = state;

    // Tone readout for the channel named by 'active'; all three fields share
    // one register stage so they stay aligned. Out-of-range channels read 0.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            freq      <= '0;
            volume    <= '0;
            ch_enable <= 1'b0;
        end else begin
            freq      <= '0;
            volume    <= '0;
            ch_enable <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (int'(active) == c) begin
                    freq      <= freq_q[c];
                    volume    <= vol_q[c];
                    ch_enable <= en_q[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_scc_register_bank.sv
// Directed bench for scc_register_bank (NUM_CH=5, FREQ_W=12, VOL_W=4, TIMEOUT=15).
// Bus responses and SRAM strobes are predicted into queues when stimulus is
// issued and popped by an independent negedge monitor.
module tb_scc_register_bank;
    localparam int NUM_CH  = 5;
    localparam int FREQ_W  = 12;
    localparam int VOL_W   = 4;
    localparam int TIMEOUT = 15;

    logic                clk;
    logic                nreset;
    logic                enable;
    logic [2:0]          sram_id;
    logic [4:0]          sram_a;
    logic [7:0]          sram_d;
    logic                sram_oe;
    logic                sram_we;
    logic [7:0]          sram_q;
    logic                sram_q_en;
    logic [2:0]          active;
    logic [FREQ_W-1:0]   freq;
    logic [VOL_W-1:0]    volume;
    logic                ch_enable;
    logic                wave_reset;
    logic [NUM_CH-1:0]   clear_counter;
    logic [2:0]          fsm_state;

    scc_register_bank_if bus ();

    scc_register_bank #(
        .NUM_CH (NUM_CH),
        .FREQ_W (FREQ_W),
        .VOL_W  (VOL_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .nreset       (nreset),
        .enable       (enable),
        .bus          (bus),
        .sram_id      (sram_id),
        .sram_a       (sram_a),
        .sram_d       (sram_d),
        .sram_oe      (sram_oe),
        .sram_we      (sram_we),
        .sram_q       (sram_q),
        .sram_q_en    (sram_q_en),
        .active       (active),
        .freq         (freq),
        .volume       (volume),
        .ch_enable    (ch_enable),
        .wave_reset   (wave_reset),
        .clear_counter(clear_counter),
        .fsm_state    (fsm_state)
    );

    int          vectors;
    int          miscompares;
    int          cyc;
    logic        prev_strobe;
    logic [7:0]  exp_q[$];
    logic [16:0] strobe_q[$];

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Clock-enable strobe: high one clk in three
    initial begin
        enable = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            enable = (cyc % 3 == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: bus responses and SRAM strobes against their expected queues
    initial prev_strobe = 1'b0;
    always @(negedge clk) begin
        if (nreset && bus.ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ready: got ready rddata %0h expected no ready", bus.rddata);
            end else begin
                check("rddata", 32'(bus.rddata), 32'(exp_q.pop_front()));
            end
        end
        if (nreset && (sram_oe || sram_we)) begin
            check("strobe_exclusive", 32'(sram_oe & sram_we), 32'h0);
            check("strobe_back_to_back", 32'(prev_strobe), 32'h0);
            if (strobe_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: got oe=%0b we=%0b expected none", sram_oe, sram_we);
            end else begin
                check("strobe_fields", 32'({sram_we, sram_id, sram_a, sram_d}), 32'(strobe_q.pop_front()));
            end
        end
        prev_strobe = sram_oe | sram_we;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-clk bus request; called at posedge+1, returns at the next posedge+1
    task automatic access(input logic w, input logic [8:0] a, input logic [7:0] d);
        bus.req     = 1'b1;
        bus.wr      = w;
        bus.address = a;
        bus.wrdata  = d;
        step();
        bus.req     = 1'b0;
        bus.wr      = 1'b0;
        bus.address = '0;
        bus.wrdata  = '0;
    endtask

    task automatic wait_ready(input int max_cycles, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                at_cyc = cyc;
                break;
            end
        end
        if (at_cyc < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got no ready expected ready within %0d clks", max_cycles);
        end
    endtask

    task automatic wait_oe(input int max_cycles, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (sram_oe) begin
                at_cyc = cyc;
                break;
            end
        end
        if (at_cyc < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL oe_timeout: got no sram_oe expected one within %0d clks", max_cycles);
        end
    endtask

    int c0;
    int c1;
    int st_seen;

    // Directed stimulus
    initial begin
        vectors     = 0;
        miscompares = 0;
        nreset      = 1'b0;
        bus.req     = 1'b0;
        bus.wr      = 1'b0;
        bus.address = '0;
        bus.wrdata  = '0;
        sram_q      = '0;
        sram_q_en   = 1'b0;
        active      = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(bus.ready), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_freq", 32'(freq), 32'h0);
        check("reset_strobes", 32'({sram_oe, sram_we}), 32'h0);
        check("reset_state", 32'(fsm_state), 32'h0);
        nreset = 1'b1;
        step();

        // Frequency write, clear pulses, old-then-new readout
        exp_q.push_back(8'h00);
        access(1'b1, 9'h100, 8'h34);
        check("clr_after_lo", 32'(clear_counter), 32'h01);
        exp_q.push_back(8'h00);
        access(1'b1, 9'h101, 8'h0F);
        check("clr_after_hi", 32'(clear_counter), 32'h01);
        check("freq_old_value", 32'(freq), 32'h034);
        step();
        check("clr_gone", 32'(clear_counter), 32'h00);
        check("freq_ch0", 32'(freq), 32'hF34);
        exp_q.push_back(8'h0F);
        access(1'b0, 9'h101, 8'h00);
        exp_q.push_back(8'h34);
        access(1'b0, 9'h100, 8'h00);

        // Volume, enable mask, mode (unused bits dropped)
        exp_q.push_back(8'h00);
        access(1'b1, 9'h10A, 8'h1B);
        exp_q.push_back(8'h00);
        access(1'b1, 9'h10F, 8'hFF);
        exp_q.push_back(8'h00);
        access(1'b1, 9'h110, 8'h20);
        step();
        check("volume_ch0", 32'(volume), 32'hB);
        check("ch_enable_ch0", 32'(ch_enable), 32'h1);
        check("wave_reset", 32'(wave_reset), 32'h1);
        exp_q.push_back(8'h0B);
        access(1'b0, 9'h10A, 8'h00);
        exp_q.push_back(8'h1F);
        access(1'b0, 9'h10F, 8'h00);

        // High byte of last channel
        exp_q.push_back(8'h00);
        access(1'b1, 9'h109, 8'hFF);
        check("clr_ch4", 32'(clear_counter), 32'h10);
        exp_q.push_back(8'h0F);
        access(1'b0, 9'h109, 8'h00);
        active = 3'd4;
        step();
        step();
        check("freq_ch4", 32'(freq), 32'hF00);

        // Wave write ch2 idx7
        strobe_q.push_back({1'b1, 3'd2, 5'd7, 8'hA5});
        exp_q.push_back(8'h00);
        access(1'b1, 9'h047, 8'hA5);
        check("busy_during_write", 32'(bus.busy), 32'h1);
        wait_ready(20, c1);
        check("busy_at_done", 32'(bus.busy), 32'h0);
        step();

        // sram_q_en while idle is ignored
        sram_q_en = 1'b1;
        sram_q    = 8'h77;
        step();
        sram_q_en = 1'b0;
        step();

        // Wave read ch1 idx3 answered 3 clks after oe
        strobe_q.push_back({1'b0, 3'd1, 5'd3, 8'h00});
        exp_q.push_back(8'h5C);
        access(1'b0, 9'h023, 8'h00);
        wait_oe(20, c0);
        repeat (3) @(posedge clk);
        #1;
        sram_q_en = 1'b1;
        sram_q    = 8'h5C;
        step();
        sram_q_en = 1'b0;
        sram_q    = 8'h00;
        wait_ready(10, c1);
        check("read_latency", 32'(c1 - c0), 32'd4);
        step();

        // Wave read with no response: timeout
        strobe_q.push_back({1'b0, 3'd1, 5'd3, 8'h00});
        exp_q.push_back(8'hFF);
        access(1'b0, 9'h023, 8'h00);
        wait_oe(20, c0);
        wait_ready(40, c1);
        check("timeout_latency", 32'(c1 - c0), 32'(TIMEOUT + 1));
        step();

        // req while busy is dropped
        strobe_q.push_back({1'b0, 3'd0, 5'd0, 8'h00});
        exp_q.push_back(8'hFF);
        access(1'b0, 9'h000, 8'h00);
        check("busy_set", 32'(bus.busy), 32'h1);
        access(1'b0, 9'h100, 8'h00);
        wait_ready(40, c1);
        repeat (5) step();

        // Reset while waiting for SRAM data: no ready, everything cleared
        strobe_q.push_back({1'b0, 3'd3, 5'd4, 8'h00});
        access(1'b0, 9'h064, 8'h00);
        st_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fsm_state == 3'd3) begin
                st_seen = 1;
                break;
            end
        end
        check("reached_wait", 32'(st_seen), 32'h1);
        @(posedge clk);
        #1;
        nreset = 1'b0;
        step();
        check("rst_ready", 32'(bus.ready), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_rddata", 32'(bus.rddata), 32'h0);
        check("rst_sram", 32'({sram_id, sram_a, sram_d, sram_oe, sram_we}), 32'h0);
        check("rst_tone", 32'({freq, volume, ch_enable, wave_reset}), 32'h0);
        check("rst_state", 32'(fsm_state), 32'h0);
        nreset = 1'b1;
        repeat (20) step();

        // Out-of-range active channel, unmapped offsets, invalid wave channel
        exp_q.push_back(8'h00);
        access(1'b1, 9'h100, 8'h55);
        exp_q.push_back(8'h00);
        access(1'b1, 9'h10A, 8'h03);
        exp_q.push_back(8'h00);
        access(1'b1, 9'h10F, 8'h01);
        active = 3'd0;
        step();
        step();
        check("freq_after_reset", 32'(freq), 32'h055);
        check("tone_ch0", 32'({volume, ch_enable}), 32'h7);
        active = 3'd5;
        step();
        check("inactive_ch_tone", 32'({freq, volume, ch_enable}), 32'h0);
        exp_q.push_back(8'hFF);
        access(1'b0, 9'h13F, 8'h00);
        exp_q.push_back(8'h01);
        access(1'b0, 9'h10F, 8'h00);
        exp_q.push_back(8'h00);
        access(1'b1, 9'h111, 8'hAA);
        exp_q.push_back(8'hFF);
        access(1'b0, 9'h111, 8'h00);
        exp_q.push_back(8'h00);
        access(1'b1, 9'h0A0, 8'h99);
        check("invalid_ch_busy", 32'(bus.busy), 32'h0);
        exp_q.push_back(8'hFF);
        access(1'b0, 9'h0E0, 8'h00);
        repeat (5) step();

        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        check("strobe_q_drained", 32'(strobe_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
